// File: rtl/led_frame_pkg.sv
// Shared types and constants for the LED frame arbiter.
package led_frame_pkg;
  localparam int COL_W    = 2;
  localparam int ROW_W    = 8;
  localparam int NUM_COLS = 4;
  localparam logic [ROW_W-1:0] LEDS_OFF = 8'hFF;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, WAIT_SYNC} frame_state_t;
  typedef enum logic {WR_A = 1'b0, WR_B = 1'b1} writer_t;
endpackage

// File: rtl/led_frame_arbiter_rr.sv
// Two-way round-robin arbiter: a tie goes to the writer that did not own the last frame.
module led_rr_arb2 (
  input  logic       i_a_valid,
  input  logic       i_b_valid,
  input  logic       i_last_owner,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = '0;
    if (i_a_valid && i_b_valid) begin
      if (i_last_owner) o_grant[0] = 1'b1;
      else              o_grant[1] = 1'b1;
    end else begin
      o_grant[0] = i_a_valid;
      o_grant[1] = i_b_valid;
    end
  end
endmodule

// File: rtl/led_frame_arbiter.sv
// Double-buffered 4x8 LED frame store shared by two writers; swaps on frame_sync after commit.
module led_frame_arbiter
  import led_frame_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic             clk12MHz,
  input  logic             rst_n,
  input  logic             frame_sync,
  input  logic             a_valid,
  input  logic [COL_W-1:0] a_col,
  input  logic [ROW_W-1:0] a_data,
  input  logic             a_commit,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [COL_W-1:0] b_col,
  input  logic [ROW_W-1:0] b_data,
  input  logic             b_commit,
  output logic             b_ready,
  output logic [ROW_W-1:0] leds1,
  output logic [ROW_W-1:0] leds2,
  output logic [ROW_W-1:0] leds3,
  output logic [ROW_W-1:0] leds4,
  output logic             swap_pending,
  output logic             abort
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  frame_state_t r_state, w_state_nxt;
  writer_t      r_last_owner, r_committer;
  logic [NUM_COLS-1:0][ROW_W-1:0] r_front, r_back;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;

  logic [1:0]       w_grant;
  logic             w_a_rdy, w_b_rdy, w_a_acc, w_b_acc, w_acc, w_timeout;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_data;
  logic             w_commit;

  led_rr_arb2 u_arb (
    .i_a_valid    (a_valid),
    .i_b_valid    (b_valid),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_rdy     = 1'b0;
    w_b_rdy     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:    begin w_a_rdy = w_grant[0]; w_b_rdy = w_grant[1]; end
      OWN_A:   w_a_rdy = 1'b1;
      OWN_B:   w_b_rdy = 1'b1;
      default: ;
    endcase
    // Ready is forced low while reset is asserted, even if a writer is valid.
    w_a_rdy  = w_a_rdy & rst_n;
    w_b_rdy  = w_b_rdy & rst_n;
    w_a_acc  = a_valid & w_a_rdy;
    w_b_acc  = b_valid & w_b_rdy;
    w_acc    = w_a_acc | w_b_acc;
    w_col    = w_b_acc ? b_col    : a_col;
    w_data   = w_b_acc ? b_data   : a_data;
    w_commit = w_b_acc ? b_commit : a_commit;
    case (r_state)
      IDLE:
        if (w_acc) w_state_nxt = w_commit ? WAIT_SYNC : (w_b_acc ? OWN_B : OWN_A);
      OWN_A, OWN_B:
        if (w_acc && w_commit) w_state_nxt = WAIT_SYNC;
        else if (!w_acc && r_cnt == CNT_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      WAIT_SYNC:
        if (frame_sync) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_front      <= {NUM_COLS{LEDS_OFF}};
      r_back       <= {NUM_COLS{LEDS_OFF}};
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_last_owner <= WR_B;
      r_committer  <= WR_B;
    end else begin
      r_abort <= w_timeout;
      if (w_acc) begin
        r_back[w_col] <= w_data;
        if (w_commit) r_committer <= w_b_acc ? WR_B : WR_A;
      end else if (w_timeout) begin
        r_back <= r_front;
      end
      if (r_state == WAIT_SYNC && frame_sync) begin
        r_front      <= r_back;
        r_last_owner <= r_committer;
      end
      if (w_timeout) r_last_owner <= (r_state == OWN_B) ? WR_B : WR_A;
      // Counts idle cycles only while a writer owns the frame; any beat restarts it.
      if ((r_state == OWN_A || r_state == OWN_B) && !w_acc && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
    end
  end

  assign a_ready      = w_a_rdy;
  assign b_ready      = w_b_rdy;
  assign leds1        = r_front[0];
  assign leds2        = r_front[1];
  assign leds3        = r_front[2];
  assign leds4        = r_front[3];
  assign swap_pending = (r_state == WAIT_SYNC);
  assign abort        = r_abort;
endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter: vector table plus hand-written corner sequences.
module tb_led_frame_arbiter;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n, frame_sync;
  logic       a_valid, a_commit, a_ready, b_valid, b_commit, b_ready;
  logic [1:0] a_col, b_col;
  logic [7:0] a_data, b_data, leds1, leds2, leds3, leds4;
  logic       swap_pending, abort;
  logic [31:0] w_leds;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  assign w_leds = {leds4, leds3, leds2, leds1};

  led_frame_arbiter #(.TIMEOUT(TO)) dut (
    .clk12MHz(clk), .rst_n(rst_n), .frame_sync(frame_sync),
    .a_valid(a_valid), .a_col(a_col), .a_data(a_data), .a_commit(a_commit), .a_ready(a_ready),
    .b_valid(b_valid), .b_col(b_col), .b_data(b_data), .b_commit(b_commit), .b_ready(b_ready),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
    .swap_pending(swap_pending), .abort(abort)
  );

  typedef struct {
    logic av; logic [1:0] ac; logic [7:0] ad; logic acm;
    logic bv; logic [1:0] bc; logic [7:0] bd; logic bcm;
    logic sy;
    logic ea; logic eb; logic esw; logic [31:0] eled;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drv(input logic av, input logic [1:0] ac, input logic [7:0] ad, input logic acm,
                     input logic bv, input logic [1:0] bc, input logic [7:0] bd, input logic bcm,
                     input logic sy);
    @(negedge clk);
    a_valid = av; a_col = ac; a_data = ad; a_commit = acm;
    b_valid = bv; b_col = bc; b_data = bd; b_commit = bcm;
    frame_sync = sy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    a_valid = 0; a_col = 0; a_data = 0; a_commit = 0;
    b_valid = 0; b_col = 0; b_data = 0; b_commit = 0;
    frame_sync = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int i);
    drv(v.av, v.ac, v.ad, v.acm, v.bv, v.bc, v.bd, v.bcm, v.sy);
    chk($sformatf("v%0d a_ready", i), {31'd0, a_ready}, {31'd0, v.ea});
    chk($sformatf("v%0d b_ready", i), {31'd0, b_ready}, {31'd0, v.eb});
    tick;
    chk($sformatf("v%0d swap_pending", i), {31'd0, swap_pending}, {31'd0, v.esw});
    chk($sformatf("v%0d leds", i), w_leds, v.eled);
  endtask

  initial begin
    // Writer A loads a full frame with commit on the last beat, then a sync swaps it in.
    tbl[0] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 32'hFFFFFFFF};
    tbl[1] = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 32'hFFFFFFFF};
    tbl[2] = '{1, 1, 8'h0F, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 32'hFFFFFFFF};
    tbl[3] = '{1, 2, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 32'hFFFFFFFF};
    tbl[4] = '{1, 3, 8'hAA, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 32'hFFFFFFFF};
    tbl[5] = '{0, 0, 8'h00, 0, 1, 2, 8'h5A, 0, 0, 0, 0, 1, 32'hFFFFFFFF};
    tbl[6] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 32'hAAF00F00};

    // Ready must stay low while reset is held, even with both writers valid.
    rst_n = 1'b0;
    a_valid = 1; b_valid = 1; a_col = 0; b_col = 0; a_data = 0; b_data = 0;
    a_commit = 0; b_commit = 0; frame_sync = 0;
    #1;
    chk("rst a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst b_ready", {31'd0, b_ready}, 32'd0);
    do_reset;
    #1;
    chk("rst leds", w_leds, 32'hFFFFFFFF);
    chk("rst swap_pending", {31'd0, swap_pending}, 32'd0);
    chk("rst abort", {31'd0, abort}, 32'd0);

    for (int i = 0; i < 7; i++) apply(tbl[i], i);

    // Tie after reset goes to A; A keeps ownership until its swap; next tie goes to B.
    do_reset;
    drv(1, 0, 8'h01, 0, 1, 0, 8'hEE, 0, 0);
    chk("tie1 a_ready", {31'd0, a_ready}, 32'd1);
    chk("tie1 b_ready", {31'd0, b_ready}, 32'd0);
    tick;
    drv(1, 1, 8'h02, 1, 1, 0, 8'hEE, 0, 0);
    chk("ownA a_ready", {31'd0, a_ready}, 32'd1);
    chk("ownA b_ready", {31'd0, b_ready}, 32'd0);
    tick;
    chk("ownA swap_pending", {31'd0, swap_pending}, 32'd1);
    drv(0, 0, 8'h00, 0, 1, 0, 8'hEE, 0, 1);
    chk("wait a_ready", {31'd0, a_ready}, 32'd0);
    chk("wait b_ready", {31'd0, b_ready}, 32'd0);
    tick;
    chk("tie swap leds", w_leds, 32'hFFFF0201);
    chk("tie swap_pending", {31'd0, swap_pending}, 32'd0);
    drv(1, 2, 8'h99, 0, 1, 0, 8'h33, 0, 0);
    chk("tie2 a_ready", {31'd0, a_ready}, 32'd0);
    chk("tie2 b_ready", {31'd0, b_ready}, 32'd1);
    tick;
    drv(1, 2, 8'h99, 0, 1, 1, 8'h44, 0, 0);
    chk("ownB b_ready", {31'd0, b_ready}, 32'd1);
    tick;

    // Asynchronous reset mid-frame in OWN_B.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst leds", w_leds, 32'hFFFFFFFF);
    chk("async rst b_ready", {31'd0, b_ready}, 32'd0);
    chk("async rst swap_pending", {31'd0, swap_pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_col = 0; b_col = 0;
    #1;
    chk("post rst tie a_ready", {31'd0, a_ready}, 32'd1);
    chk("post rst tie b_ready", {31'd0, b_ready}, 32'd0);

    // Timeout: a single beat then TIMEOUT idle cycles discards the frame.
    do_reset;
    drv(1, 2, 8'h55, 0, 0, 0, 8'h00, 0, 0);
    tick;
    for (int k = 1; k <= TO; k++) begin
      drv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, (k == 5));
      tick;
      chk($sformatf("to abort k%0d", k), {31'd0, abort}, {31'd0, (k == TO)});
      if (k == 5) chk("sync ignored in OWN", w_leds, 32'hFFFFFFFF);
    end
    drv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    tick;
    chk("abort single pulse", {31'd0, abort}, 32'd0);
    drv(1, 0, 8'h12, 1, 0, 0, 8'h00, 0, 0);
    chk("after to a_ready", {31'd0, a_ready}, 32'd1);
    tick;
    chk("after to swap_pending", {31'd0, swap_pending}, 32'd1);
    drv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    tick;
    chk("after to leds", w_leds, 32'hFFFFFF12);

    // A commit accepted together with frame_sync must wait for the next pulse.
    do_reset;
    drv(1, 3, 8'h77, 1, 0, 0, 8'h00, 0, 1);
    tick;
    chk("cs swap_pending", {31'd0, swap_pending}, 32'd1);
    chk("cs no swap", w_leds, 32'hFFFFFFFF);
    drv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    tick;
    chk("cs still pending", {31'd0, swap_pending}, 32'd1);
    drv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    tick;
    chk("cs swapped leds", w_leds, 32'h77FFFFFF);
    chk("cs swap_pending clr", {31'd0, swap_pending}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
